// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcode constants, instruction field positions and sequencer states.
package instr_sequencer_pkg;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_LOOP = 4'hE;
    localparam logic [3:0] OP_ENDL = 4'hD;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int CNT_MSB = 7;
    localparam int CNT_LSB = 0;
    localparam int CNT_WIDTH = CNT_MSB - CNT_LSB + 1;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE} state_t;
endpackage

// File: rtl/instr_sequencer_loop_ctrl.sv
// loop_ctrl: single-level hardware loop registers (return address, remaining count, active flag).
module loop_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set,
    input  logic                  dec,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] set_start,
    input  logic [CNT_WIDTH-1:0]  set_cnt,
    output logic [ADDR_WIDTH-1:0] loop_start,
    output logic [CNT_WIDTH-1:0]  loop_cnt,
    output logic                  loop_active,
    output logic                  loop_more
);
    // counts 0 and 1 both fall through on the first ENDL
    assign loop_more = loop_cnt > CNT_WIDTH'(1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loop_start  <= '0;
            loop_cnt    <= '0;
            loop_active <= 1'b0;
        end else if (set) begin
            loop_start  <= set_start;
            loop_cnt    <= set_cnt;
            loop_active <= 1'b1;
        end else if (dec) begin
            loop_cnt <= loop_cnt - 1'b1;
        end else if (clear) begin
            loop_cnt    <= '0;
            loop_active <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches from a synchronous instruction memory, runs HALT/LOOP/ENDL
// internally and issues every other instruction over a valid/ready handshake.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    output logic                   imem_rd_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH-1:0]  pc_out
);
    state_t state;
    logic [ADDR_WIDTH-1:0] pc, pc_next, loop_start;
    logic [CNT_WIDTH-1:0] loop_cnt;
    logic [3:0] op;
    logic loop_active, loop_more, in_decode, is_halt, is_loop, is_endl, fault;

    assign op        = imem_data[OPC_MSB:OPC_LSB];
    assign pc_next   = pc + 1'b1;
    assign in_decode = state == S_DECODE;
    assign is_halt   = in_decode && op == OP_HALT;
    assign is_loop   = in_decode && op == OP_LOOP;
    assign is_endl   = in_decode && op == OP_ENDL;
    assign fault     = (is_loop && loop_active) || (is_endl && !loop_active);
    // done is decoded straight from the memory word so it lands in the DECODE cycle
    assign done        = is_halt || fault;
    assign busy        = state != S_IDLE;
    assign imem_rd_en  = state == S_FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == S_ISSUE;
    assign pc_out      = pc;

    loop_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_loop_ctrl (
        .clock      (clock),
        .reset      (reset),
        .set        (is_loop && !loop_active),
        .dec        (is_endl && loop_active && loop_more),
        .clear      ((is_endl && loop_active && !loop_more) || (state == S_IDLE && start)),
        .set_start  (pc_next),
        .set_cnt    (imem_data[CNT_MSB:CNT_LSB]),
        .loop_start (loop_start),
        .loop_cnt   (loop_cnt),
        .loop_active(loop_active),
        .loop_more  (loop_more)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr_out <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pc    <= start_addr;
                    error <= 1'b0;
                    state <= S_FETCH;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (fault) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else if (is_halt) begin
                        state <= S_IDLE;
                    end else if (is_loop) begin
                        pc    <= pc_next;
                        state <= S_FETCH;
                    end else if (is_endl) begin
                        pc    <= loop_more ? loop_start : pc_next;
                        state <= S_FETCH;
                    end else begin
                        instr_out <= imem_data;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: if (instr_ready) begin
                    pc    <= pc_next;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed programs against a program-level
// interpreter; issued instructions are checked by a scoreboard monitor.
module tb_instr_sequencer;
    logic        clock = 1'b0;
    logic        reset, start, instr_ready;
    logic [7:0]  start_addr, imem_addr, pc_out;
    logic [15:0] imem_data, instr_out;
    logic        imem_rd_en, instr_valid, busy, done, error;

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    int          vq [$];
    int          cyc = 0, t0 = 0, n_issue = 0, n_chk = 0, n_fail = 0, rdy_pct = 100;
    bit          rdy_auto = 1'b0;

    instr_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .done(done), .error(error), .pc_out(pc_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (imem_rd_en) imem_data <= mem[imem_addr];
    always @(posedge clock) begin
        #2;
        if (rdy_auto) instr_ready = $urandom_range(99) < rdy_pct;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) if (!reset) begin
        chk("done_and_valid_exclusive", done && instr_valid, 0);
        if (instr_valid && instr_ready) begin
            n_issue++;
            vq.push_back(cyc - t0);
            if (exp_q.size() == 0) chk("issue_unexpected", instr_out, 32'hFFFF_FFFF);
            else chk("issue_data", instr_out, exp_q.pop_front());
        end
    end

    // program interpreter: issued stream and error outcome
    task automatic model(input logic [7:0] sa, output logic e, output int n);
        logic [7:0]  pc = sa, ls = 8'd0;
        logic [15:0] ins;
        int          cnt = 0;
        bit          act = 1'b0;
        e = 1'b0;
        n = 0;
        for (int s = 0; s < 5000; s++) begin
            ins = mem[pc];
            case (ins[15:12])
                4'hF: return;
                4'hE: if (act) begin e = 1'b1; return; end
                      else begin act = 1'b1; ls = pc + 8'd1; cnt = int'(ins[7:0]); pc = pc + 8'd1; end
                4'hD: if (!act) begin e = 1'b1; return; end
                      else if (cnt > 1) begin cnt--; pc = ls; end
                      else begin act = 1'b0; pc = pc + 8'd1; end
                default: begin exp_q.push_back(ins); n++; pc = pc + 8'd1; end
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_start(input logic [7:0] a);
        @(posedge clock); #1;
        start = 1'b1; start_addr = a; t0 = cyc; vq.delete();
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic hard_reset();
        @(posedge clock); #3; reset = 1'b1;
        @(negedge clock); exp_q.delete();
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!instr_valid && k < 50) begin @(negedge clock); k++; end
        chk("valid_wait", instr_valid, 1);
    endtask

    task automatic wait_done(output int dc, output bit ok);
        int k = 0;
        while (!done && k < 3000) begin @(negedge clock); k++; end
        ok = done;
        dc = cyc - t0;
        chk("done_wait", ok, 1);
        if (!ok) hard_reset();
    endtask

    task automatic finish_run(input logic e, input int n, input int i0);
        @(negedge clock);
        chk("error_flag", error, e);
        chk("busy_after", busy, 0);
        chk("issue_count_model", n_issue - i0, n);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_prog(input logic [7:0] sa, output int dc);
        logic e;
        int   n, i0;
        bit   ok;
        exp_q.delete();
        model(sa, e, n);
        i0 = n_issue;
        do_start(sa);
        @(negedge clock);
        chk("error_cleared_by_start", error, 0);
        wait_done(dc, ok);
        if (ok) finish_run(e, n, i0);
    endtask

    initial begin
        int   dc, i0, n;
        logic e;
        bit   ok;
        reset = 1'b1; start = 1'b0; start_addr = 8'd0; instr_ready = 1'b0;
        clear_mem();
        @(negedge clock);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instr_out, 0);
        reset = 1'b0;

        // linear program with ready tied high
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'hF000;
        rdy_auto = 1'b1; rdy_pct = 100;
        run_prog(8'd0, dc);
        chk("lin_done_cycle", dc, 8);
        chk("lin_issue_n", vq.size(), 2);
        chk("lin_valid_cyc0", vq.size() > 0 ? vq[0] : -1, 3);
        chk("lin_valid_cyc1", vq.size() > 1 ? vq[1] : -1, 6);

        // backpressure
        clear_mem();
        mem[0] = 16'h1234;
        rdy_auto = 1'b0; instr_ready = 1'b0;
        exp_q.delete();
        model(8'd0, e, n);
        i0 = n_issue;
        do_start(8'd0);
        wait_valid();
        repeat (5) begin
            @(negedge clock);
            chk("bp_instr_stable", instr_out, 16'h1234);
            chk("bp_pc_hold", pc_out, 0);
            chk("bp_valid_hold", instr_valid, 1);
        end
        @(posedge clock); #2; instr_ready = 1'b1;
        @(posedge clock); #2; instr_ready = 1'b0;
        wait_done(dc, ok);
        if (ok) finish_run(e, n, i0);
        chk("bp_single_issue", n_issue - i0, 1);
        rdy_auto = 1'b1;

        // loop of 3
        clear_mem();
        mem[0] = 16'hE003; mem[1] = 16'h1111; mem[2] = 16'hD000;
        i0 = n_issue;
        run_prog(8'd0, dc);
        chk("loop3_issues", n_issue - i0, 3);

        // count-0 loop
        clear_mem();
        mem[0] = 16'hE000; mem[1] = 16'h2222; mem[2] = 16'hD000;
        i0 = n_issue;
        run_prog(8'd0, dc);
        chk("loop0_issues", n_issue - i0, 1);

        // nested loop fault
        clear_mem();
        mem[0] = 16'hE002; mem[1] = 16'h1111; mem[2] = 16'hE002; mem[3] = 16'hD000;
        run_prog(8'd0, dc);
        chk("nested_error", error, 1);

        // lone ENDL fault
        clear_mem();
        mem[0] = 16'hD000;
        run_prog(8'd0, dc);
        chk("lone_endl_error", error, 1);
        chk("lone_endl_done_cycle", dc, 2);

        // PC wrap from FF to 00
        clear_mem();
        mem[8'hFF] = 16'h1234; mem[0] = 16'hF000;
        run_prog(8'hFF, dc);
        chk("wrap_done_cycle", dc, 5);

        // async reset while an instruction is waiting to issue
        rdy_auto = 1'b0; instr_ready = 1'b0;
        do_start(8'hFF);
        wait_valid();
        @(posedge clock); #3; reset = 1'b1;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pc", pc_out, 0);
        chk("arst_done", done, 0);
        exp_q.delete();
        @(negedge clock); reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("post_arst_no_done", done, 0);
            chk("post_arst_idle", busy, 0);
        end
        rdy_auto = 1'b1;

        // randomized programs
        for (int r = 0; r < 25; r++) begin
            logic [7:0] base, idx;
            int len, p;
            clear_mem();
            base = 8'($urandom_range(255));
            len = $urandom_range(3, 12);
            for (int i = 0; i < len; i++) begin
                idx = base + 8'(i);
                p = $urandom_range(99);
                if (p < 70) mem[idx] = {4'($urandom_range(12)), 12'($urandom)};
                else if (p < 82) mem[idx] = {4'hE, 4'($urandom), 8'($urandom_range(3))};
                else if (p < 94) mem[idx] = {4'hD, 12'($urandom)};
                else mem[idx] = {4'hF, 12'($urandom)};
            end
            rdy_pct = $urandom_range(30, 100);
            run_prog(base, dc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch and issue unit. It is the producer end of the 16-bit instruction bus that the autoencoder datapath consumes; the datapath's CU decodes instr[15:12], and the three 4-bit fields select memory sectors.
- Reads a synchronous instruction memory and handles HALT and single-level hardware loops internally.
- Presents every other instruction to the datapath over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width.
- INSTR_WIDTH, 16, instruction width: opcode[15:12], f1[11:8], f2[7:4], f3[3:0].
- OP_HALT, 4'hF, end-of-program opcode.
- OP_LOOP, 4'hE, loop-start opcode; iteration count in instr[7:0].
- OP_ENDL, 4'hD, loop-end opcode.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins execution at start_addr when idle.
- start_addr  in  ADDR_WIDTH  first program address.
- imem_rd_en  out  1  instruction memory read strobe.
- imem_addr  out  ADDR_WIDTH  instruction memory address.
- imem_data  in  INSTR_WIDTH  memory read data, valid 1 cycle after the rd_en cycle.
- instr_out  out  INSTR_WIDTH  issued instruction to the datapath.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  datapath accepts instr_out.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on HALT or error termination.
- error  out  1  sticky fault flag; cleared by reset or by an accepted start.
- pc_out  out  ADDR_WIDTH  current program counter.

Behaviour:
- Reset (asynchronous): state=IDLE, pc=0, loop_start=0, loop_cnt=0, loop_active=0. All outputs are 0.
- States: IDLE, FETCH, DECODE, ISSUE.
- IDLE:
  - start=1 loads pc=start_addr, clears error, goes to FETCH.
  - start is ignored in every other state.
- FETCH: imem_rd_en=1, imem_addr=pc; next state DECODE.
- DECODE: sample imem_data and act on the opcode.
  - Ordinary opcode: register it into instr_out, go to ISSUE.
  - OP_HALT: not issued; done=1 for one cycle, go to IDLE.
  - OP_LOOP:
    - If loop_active=0: not issued; loop_start=pc+1, loop_cnt=instr[7:0], loop_active=1, pc=pc+1, go to FETCH.
    - If loop_active=1 (nested loop): error=1, done pulse, go to IDLE.
  - OP_ENDL:
    - If loop_active=0: error=1, done pulse, go to IDLE.
    - If loop_cnt>1: loop_cnt-1, pc=loop_start, go to FETCH.
    - Otherwise: loop_active=0, pc=pc+1, go to FETCH.
    - Count values 0 and 1 both execute the loop body once.
- ISSUE: instr_valid=1.
  - instr_out is held stable while instr_valid=1 and instr_ready=0.
  - On instr_valid and instr_ready: pc=pc+1, go to FETCH. instr_valid drops the next cycle.
  - instr_ready asserted early (before instr_valid) has no effect.
- Latency:
  - start sampled in cycle 0 gives instr_valid in cycle 3.
  - Minimum issue rate is one instruction per 3 cycles.
  - Each loop/endl control instruction adds 2 cycles.
- The PC increments modulo 2^ADDR_WIDTH (wrap from all-ones to 0), including loop_start.
- Reset asserted mid-operation aborts immediately. Outputs go to their reset values, with no done pulse.
- done and instr_valid are never high in the same cycle.

Decomposition:
- Shared package/header: opcode constants OP_HALT, OP_LOOP, OP_ENDL, the field bit ranges, and the state encodings.
- The datapath CU uses the same opcode header.
- One natural sub-module: loop_ctrl, holding loop_start, loop_cnt and loop_active, with set, end-test and clear controls. The FSM stays in instr_sequencer.

Test Plan:
- Linear program: mem[0..2]=16'h1234,16'h2345,16'hF000, start_addr=0, ready tied 1. Required response:
  - instr_valid in cycles 3 and 6 carrying 1234 then 2345.
  - done pulse in cycle 8.
  - busy low afterwards.
- Backpressure: hold instr_ready=0 for 5 cycles while 16'h1234 is valid. Required response:
  - instr_out stays stable.
  - pc_out does not advance until ready=1.
  - Exactly one issue.
- Loop: mem = E003, 1111, D000, F000. Required response: 1111 issued exactly 3 times, then done.
- Count-0 loop: mem = E000, 2222, D000, F000. Required response: 2222 issued once.
- Faults:
  - Nested E002 inside an active loop gives error=1 and a done pulse.
  - A lone D000 gives the same.
  - A following start clears error.
- Async reset during ISSUE: instr_valid, busy and pc_out go to 0 without waiting for a clock edge; no done pulse. start_addr=8'hFF with mem[FF]=1234, mem[00]=F000 checks PC wrap.
